// File: rtl/pu_fifo_ring_if.sv
// pu_fifo_ring_if: PU bus bundle for pu_fifo_ring; signal_peek exists only with PU_FIFO_RING_PEEK_EN
interface pu_fifo_ring_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int LEVEL_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data_in, data_out;
  logic [ATTR_WIDTH-1:0] attr_in, attr_out;
  logic signal_wr, signal_oe, signal_flush;
  logic full, empty;
  logic [LEVEL_WIDTH-1:0] level;
`ifdef PU_FIFO_RING_PEEK_EN
  logic signal_peek;
`endif
  modport master (
`ifdef PU_FIFO_RING_PEEK_EN
    output signal_peek,
`endif
    output data_in, attr_in, signal_wr, signal_oe, signal_flush,
    input data_out, attr_out, full, empty, level
  );
  modport slave (
`ifdef PU_FIFO_RING_PEEK_EN
    input signal_peek,
`endif
    input data_in, attr_in, signal_wr, signal_oe, signal_flush,
    output data_out, attr_out, full, empty, level
  );
endinterface

// File: rtl/pu_fifo_ring.sv
// pu_fifo_ring: ring-buffer FIFO PU with over/underflow sticky error and flush; PU_FIFO_RING_PEEK_EN adds signal_peek
module pu_fifo_ring #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int FIFO_SIZE = 8,
  parameter int LEVEL_WIDTH = $clog2(FIFO_SIZE + 1)
) (
  input logic clk,
  input logic rst,
  pu_fifo_ring_if.slave bus
);
  localparam int PW = $clog2(FIFO_SIZE);
  localparam logic [PW-1:0] LAST = PW'(FIFO_SIZE - 1);
  logic [ATTR_WIDTH+DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [ATTR_WIDTH+DATA_WIDTH-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LEVEL_WIDTH-1:0] level;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ATTR_WIDTH-1:0] attr_q;
  logic sticky_err, full, empty, rd, pop, wr_ok, ovf;
  assign full = level == LEVEL_WIDTH'(FIFO_SIZE);
  assign empty = level == '0;
  assign head = mem[rd_ptr];
`ifdef PU_FIFO_RING_PEEK_EN
  assign rd = bus.signal_oe | bus.signal_peek;
`else
  assign rd = bus.signal_oe;
`endif
  assign pop = bus.signal_oe & ~empty;
  // a full FIFO still accepts a write when the same cycle pops a word
  assign wr_ok = bus.signal_wr & (~full | bus.signal_oe);
  assign ovf = bus.signal_wr & full & ~bus.signal_oe;
  always_ff @(posedge clk)
    if (wr_ok && !bus.signal_flush) mem[wr_ptr] <= {bus.attr_in, bus.data_in};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      sticky_err <= 1'b0;
      data_q <= '0;
      attr_q <= '0;
    end else if (bus.signal_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      sticky_err <= 1'b0;
      data_q <= '0;
      attr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      level <= level + LEVEL_WIDTH'(wr_ok) - LEVEL_WIDTH'(pop);
      sticky_err <= sticky_err | ovf | (rd & empty);
      data_q <= rd && !empty ? head[DATA_WIDTH-1:0] : '0;
      attr_q <= !rd ? '0 : empty ? ATTR_WIDTH'(1) : head[ATTR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] | ATTR_WIDTH'(sticky_err);
    end
  end
  assign bus.data_out = data_q;
  assign bus.attr_out = attr_q;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.level = level;
endmodule
